// File: rtl/uart_tx_sched.sv
// uart_tx_sched: programs the UART baud/control registers, then shares the
// single TX buffer among NREQ byte producers with round-robin arbitration.
// Each byte: load TX buffer, wait for uart_pnd, clear the flag, report done.
// Optional feature: define UART_SCHED_TMO_EN to add a WAIT-state timeout
// (TMO_CYC cycles) that raises the sticky tmo_err and forces the clear.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | unconfigured, requests ignored, waiting for cfg_start
// CFG_BAUD  | writing baud register
// CFG_CON   | writing control register, clearing both pending flags
// READY     | configured, arbitrating among requesters
// LOAD      | writing winner's byte to TX buffer, gnt pulse
// WAIT      | waiting for uart_pnd (first 2 cycles masked)
// CLR       | clearing TX pending flag, done pulse
module uart_tx_sched #(
    parameter int          NREQ    = 4,
    parameter logic [15:0] TMO_CYC = 16'hFFFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_baud,
    input  logic [15:0]       cfg_con,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_dat,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              uart_baud_wr,
    output logic              uart_con_wr,
    output logic              uart_txbuf_wr,
    output logic [15:0]       icb_wdat,
    input  logic              uart_pnd,
    output logic              cfg_done,
    output logic              busy,
    output logic              tmo_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE, ST_CFG_BAUD, ST_CFG_CON, ST_READY, ST_LOAD, ST_WAIT, ST_CLR
    } state_t;

    state_t            state;
    logic [15:0]       con_q;
    logic [15:0]       con_cap;
    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  cand;
    logic              rr_found;
    logic [7:0]        rr_dat;
    logic [1:0]        wait_cnt;
    logic              pnd_ok;
    logic              tmo_hit;

    // enable bit forced on, pending-flag bits kept out of the stored value
    assign con_cap = (cfg_con | 16'h0001) & ~16'h0C00;
    // pending flag only trusted once the 2-cycle mask has elapsed
    assign pnd_ok  = (wait_cnt == 2'd2) && uart_pnd;

    // round-robin search starting just after the last granted requester
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NREQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        rr_dat = req_dat[{rr_idx, 3'b000} +: 8];
    end

`ifdef UART_SCHED_TMO_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 16'd0);

    // WAIT timeout counter and sticky error flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state == ST_LOAD)
                tmo_cnt <= TMO_CYC;
            else if (state == ST_WAIT && !tmo_hit)
                tmo_cnt <= tmo_cnt - 16'd1;
            if (cfg_start && (state == ST_IDLE || state == ST_READY))
                tmo_err <= 1'b0;
            else if (state == ST_WAIT && !pnd_ok && tmo_hit)
                tmo_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // no timeout hardware: error output tied low
    assign tmo_err = 1'b0 & (|TMO_CYC);
`endif

    // sequencer FSM with registered strobes, data and pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            con_q         <= '0;
            last_gnt      <= IDX_W'(NREQ - 1);
            win_idx       <= '0;
            wait_cnt      <= '0;
            uart_baud_wr  <= 1'b0;
            uart_con_wr   <= 1'b0;
            uart_txbuf_wr <= 1'b0;
            icb_wdat      <= '0;
            gnt           <= '0;
            done          <= '0;
            cfg_done      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            uart_baud_wr  <= 1'b0;
            uart_con_wr   <= 1'b0;
            uart_txbuf_wr <= 1'b0;
            icb_wdat      <= '0;
            gnt           <= '0;
            done          <= '0;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (cfg_start) begin
                        state        <= ST_CFG_BAUD;
                        uart_baud_wr <= 1'b1;
                        icb_wdat     <= cfg_baud;
                        busy         <= 1'b1;
                    end else if (state == ST_READY && rr_found) begin
                        state         <= ST_LOAD;
                        win_idx       <= rr_idx;
                        uart_txbuf_wr <= 1'b1;
                        icb_wdat      <= {8'h00, rr_dat};
                        gnt           <= ONE_HOT0 << rr_idx;
                        busy          <= 1'b1;
                    end
                end
                ST_CFG_BAUD: begin
                    state       <= ST_CFG_CON;
                    con_q       <= con_cap;
                    uart_con_wr <= 1'b1;
                    icb_wdat    <= con_cap | 16'h0C00;
                end
                ST_CFG_CON: begin
                    state    <= ST_READY;
                    cfg_done <= 1'b1;
                    busy     <= 1'b0;
                end
                ST_LOAD: begin
                    state    <= ST_WAIT;
                    last_gnt <= win_idx;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (wait_cnt != 2'd2)
                        wait_cnt <= wait_cnt + 2'd1;
                    if (pnd_ok || tmo_hit) begin
                        state       <= ST_CLR;
                        uart_con_wr <= 1'b1;
                        icb_wdat    <= con_q | 16'h0400;
                        done        <= ONE_HOT0 << win_idx;
                    end
                end
                ST_CLR: begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_baud = 16'h0068;
    logic [15:0] cfg_con = 16'h0006;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_dat = 32'h0;
    logic [3:0]  gnt, done;
    logic        uart_baud_wr, uart_con_wr, uart_txbuf_wr;
    logic [15:0] icb_wdat;
    logic        uart_pnd = 1'b0;
    logic        cfg_done, busy, tmo_err;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_sched #(.NREQ(4), .TMO_CYC(16'd20)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start),
        .cfg_baud(cfg_baud), .cfg_con(cfg_con), .req(req), .req_dat(req_dat),
        .gnt(gnt), .done(done), .uart_baud_wr(uart_baud_wr),
        .uart_con_wr(uart_con_wr), .uart_txbuf_wr(uart_txbuf_wr),
        .icb_wdat(icb_wdat), .uart_pnd(uart_pnd), .cfg_done(cfg_done),
        .busy(busy), .tmo_err(tmo_err)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_config();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step();
        step();
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat} !== 19'h0) begin
            errors++;
            $display("FAIL reset_strobes: got %b/%h expected 000/0000",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat);
        end
        checks++;
        if ({gnt, done, cfg_done, busy, tmo_err} !== 11'h0) begin
            errors++;
            $display("FAIL reset_flags: gnt=%b done=%b cfg_done=%b busy=%b tmo_err=%b expected all 0",
                     gnt, done, cfg_done, busy, tmo_err);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_unconfigured();
        req = 4'b0001;
        req_dat = 32'h0000_0055;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, gnt, busy} !== 8'h0) begin
                errors++;
                $display("FAIL unconfigured_idle: strobes=%b gnt=%b busy=%b expected 0",
                         {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, gnt, busy);
            end
        end
    endtask

    task automatic test_config();
        cfg_baud = 16'h0068;
        cfg_con = 16'h0006;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, busy, cfg_done} !== {3'b100, 16'h0068, 2'b10}) begin
            errors++;
            $display("FAIL cfg_baud_write: strobes=%b wdat=%h busy=%b cfg_done=%b expected 100/0068/1/0",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, busy, cfg_done);
        end
        step();
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, busy, cfg_done} !== {3'b010, 16'h0C07, 2'b10}) begin
            errors++;
            $display("FAIL cfg_con_write: strobes=%b wdat=%h busy=%b cfg_done=%b expected 010/0c07/1/0",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, busy, cfg_done);
        end
        step();
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, busy, cfg_done, gnt} !== {3'b000, 16'h0000, 2'b01, 4'b0000}) begin
            errors++;
            $display("FAIL cfg_ready: strobes=%b wdat=%h busy=%b cfg_done=%b gnt=%b expected 000/0000/0/1/0000",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, busy, cfg_done, gnt);
        end
    endtask

    task automatic test_first_byte();
        step();
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, gnt, busy} !== {3'b001, 16'h0055, 4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL first_load: strobes=%b wdat=%h gnt=%b busy=%b expected 001/0055/0001/1",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, gnt, busy);
        end
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, gnt, done, busy} !== {3'b000, 16'h0, 8'h0, 1'b1}) begin
                errors++;
                $display("FAIL first_wait: strobes=%b wdat=%h busy=%b expected 000/0000/1",
                         {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, busy);
            end
        end
        uart_pnd = 1'b1;
        step();
        uart_pnd = 1'b0;
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, done} !== {3'b010, 16'h0407, 4'b0001}) begin
            errors++;
            $display("FAIL first_clear: strobes=%b wdat=%h done=%b expected 010/0407/0001",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, done);
        end
        step();
        checks++;
        if ({uart_con_wr, done, busy} !== 6'h0) begin
            errors++;
            $display("FAIL first_back_ready: con_wr=%b done=%b busy=%b expected 0/0000/0",
                     uart_con_wr, done, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx = 0;
        int n_gnt = 0;
        int n_done = 0;
        int cnt = 0;
        logic [3:0] last_g = 4'b0000;
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        do_config();
        req = 4'b1111;
        req_dat = 32'hA3A2A1A0;
        for (int c = 0; c < 200 && n_done < 5; c++) begin
            step();
            checks++;
            if ((32'($countones({uart_baud_wr, uart_con_wr, uart_txbuf_wr})) > 1) ||
                (gnt !== 4'b0000 && !uart_txbuf_wr) || (done !== 4'b0000 && !uart_con_wr)) begin
                errors++;
                $display("FAIL rr_exclusive: strobes=%b gnt=%b done=%b at cycle %0d",
                         {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, gnt, done, c);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) uart_pnd = 1'b1;
            end
            if (uart_txbuf_wr) begin
                checks++;
                if (gnt !== (4'b0001 << exp_idx) || icb_wdat !== {8'h00, 8'(8'hA0 + exp_idx)}) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: gnt=%b wdat=%h expected %b/%h", n_gnt, gnt, icb_wdat,
                             4'b0001 << exp_idx, {8'h00, 8'(8'hA0 + exp_idx)});
                end
                last_g = 4'b0001 << exp_idx;
                exp_idx = (exp_idx + 1) % 4;
                n_gnt++;
                cnt = 3;
            end
            if (uart_con_wr) begin
                checks++;
                if (done !== last_g || icb_wdat !== 16'h0407) begin
                    errors++;
                    $display("FAIL rr_done_%0d: done=%b wdat=%h expected %b/0407", n_done, done, icb_wdat, last_g);
                end
                n_done++;
                uart_pnd = 1'b0;
            end
        end
        req = 4'b0000;
        checks++;
        if (n_done != 5 || n_gnt != 5) begin
            errors++;
            $display("FAIL rr_count: grants=%0d dones=%0d expected 5/5", n_gnt, n_done);
        end
    endtask

    task automatic test_pnd_high();
        int t1 = -1, t2 = -1, c1 = -1, ncl = 0, nt = 0;
        logic [3:0] g1 = 4'b0000, g2 = 4'b0000;
        uart_pnd = 1'b1;
        req = 4'b0110;
        for (int c = 0; c < 60 && ncl < 2; c++) begin
            step();
            if (uart_txbuf_wr) begin
                if (nt == 0) begin t1 = c; g1 = gnt; end
                else begin t2 = c; g2 = gnt; req = 4'b0000; end
                nt++;
            end
            if (uart_con_wr) begin
                if (ncl == 0) c1 = c;
                ncl++;
            end
        end
        uart_pnd = 1'b0;
        checks++;
        if (ncl != 2 || g1 !== 4'b0010 || g2 !== 4'b0100) begin
            errors++;
            $display("FAIL pnd_high_order: clears=%0d gnt1=%b gnt2=%b expected 2/0010/0100", ncl, g1, g2);
        end
        checks++;
        if (t2 - t1 != 6) begin
            errors++;
            $display("FAIL pnd_high_period: got %0d cycles expected 6", t2 - t1);
        end
        checks++;
        if (c1 - t1 != 4) begin
            errors++;
            $display("FAIL pnd_high_wait: load-to-clear %0d cycles expected 4", c1 - t1);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pnd_high_ready: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int t_ld = -1;
        req = 4'b0001;
        uart_pnd = 1'b0;
        for (int c = 0; c < 10 && t_ld < 0; c++) begin
            step();
            if (uart_txbuf_wr) t_ld = c;
        end
        req = 4'b0000;
        checks++;
        if (t_ld < 0) begin
            errors++;
            $display("FAIL tmo_load: no txbuf write within 10 cycles");
        end
`ifdef UART_SCHED_TMO_EN
        begin
            int t_cl = -1;
            for (int c = 0; c < 40 && t_cl < 0; c++) begin
                step();
                if (uart_con_wr) t_cl = c + 1;
            end
            checks++;
            if (t_cl != 22 || tmo_err !== 1'b1 || done !== 4'b0001 || icb_wdat !== 16'h0407) begin
                errors++;
                $display("FAIL tmo_clear: after %0d cycles tmo_err=%b done=%b wdat=%h expected 22/1/0001/0407",
                         t_cl, tmo_err, done, icb_wdat);
            end
            step();
            checks++;
            if (tmo_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL tmo_sticky: tmo_err=%b busy=%b expected 1/0", tmo_err, busy);
            end
            cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
            checks++;
            if (tmo_err !== 1'b0 || uart_baud_wr !== 1'b1) begin
                errors++;
                $display("FAIL tmo_cfg_clear: tmo_err=%b baud_wr=%b expected 0/1", tmo_err, uart_baud_wr);
            end
            step();
            step();
        end
`else
        begin
            int seen_clr = 0;
            for (int c = 0; c < 30; c++) begin
                step();
                if (uart_con_wr) seen_clr++;
            end
            checks++;
            if (seen_clr != 0 || busy !== 1'b1 || tmo_err !== 1'b0) begin
                errors++;
                $display("FAIL no_tmo_wait: clears=%0d busy=%b tmo_err=%b expected 0/1/0", seen_clr, busy, tmo_err);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        uart_pnd = 1'b0;
        if (!busy) begin
            req = 4'b0001;
            for (int c = 0; c < 10 && !uart_txbuf_wr; c++) step();
            req = 4'b0000;
            step();
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_busy: busy=%b expected 1", busy);
        end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        checks++;
        if ({uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat, gnt, done, cfg_done, busy, tmo_err} !== 30'h0) begin
            errors++;
            $display("FAIL mid_reset: strobes=%b wdat=%h gnt=%b done=%b cfg_done=%b busy=%b tmo_err=%b expected all 0",
                     {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, icb_wdat, gnt, done, cfg_done, busy, tmo_err);
        end
        req = 4'b0001;
        req_dat = 32'hA3A2A1A0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (gnt !== 4'b0000 || uart_con_wr || uart_txbuf_wr) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_no_gnt: %0d cycles with gnt or write, expected 0", seen);
        end
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int c = 0; c < 10 && !uart_txbuf_wr; c++) step();
        checks++;
        if (uart_txbuf_wr !== 1'b1 || gnt !== 4'b0001 || icb_wdat !== 16'h00A0) begin
            errors++;
            $display("FAIL mid_reconfig_gnt: txbuf_wr=%b gnt=%b wdat=%h expected 1/0001/00a0",
                     uart_txbuf_wr, gnt, icb_wdat);
        end
        req = 4'b0000;
        uart_pnd = 1'b1;
        for (int c = 0; c < 10 && !uart_con_wr; c++) step();
        uart_pnd = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_unconfigured();
        test_config();
        test_first_byte();
        test_round_robin();
        test_pnd_high();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
